// File: rtl/bsram_arb_pkg.sv
// Shared definitions for the dual-requester BSRAM arbiter and its round-robin
// grant helper: FSM state encoding, requester index constants and a width
// helper for byte-enable masks.
package bsram_arb_pkg;

  // CLEAR sweeps the array to zero; IDLE serves requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } arb_state_t;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  // Number of byte lanes in a data word (width is expected to be a multiple of 8).
  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a single pointer register.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-low reset (pointer returns to requester 0)
//   enable  - when low no grant is issued and the pointer holds
//   req     - request vector, bit i for requester i
//   grant   - combinational one-hot (or zero) grant
//   ptr     - current pointer: the requester favoured on a tie
module rr_arbiter2
  import bsram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Any grant, contended or not, hands priority to the other requester.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      ptr <= ~grant[REQ1];
    end
  end

endmodule

// File: rtl/bsram_dual_arbiter.sv
// Shares one byte-enable synchronous BSRAM (1-cycle read latency) between two
// requesters. After reset it optionally zero-fills the array, then grants one
// request per cycle in round-robin order and returns read data one cycle after
// the grant.
//
// Handshake: a request is accepted in the cycle where req_valid[i] and
// req_ready[i] are both high. A requester holding valid must keep address,
// data and op stable until ready; a valid request is never dropped. Read data
// comes back as a single-cycle rsp_valid[i] pulse the cycle after acceptance;
// writes produce no response.
//
// Ports:
//   clock, reset               - clock, synchronous active-low reset
//   req_valid/req_write        - per-requester valid and op (1 = write)
//   req_address/_write_data/_byte_en - per-requester fields, slice i per requester
//   req_ready                  - per-requester grant (one-hot or zero)
//   rsp_valid, rsp_data        - read response pulse and shared data
//   init_done                  - high once the zero-fill has completed
//   mem_read*/mem_write*       - memory control; read data arrives on mem_readData
module bsram_dual_arbiter
  import bsram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   req_valid,
  input  logic [1:0]                   req_write,
  input  logic [2*ADDR_WIDTH-1:0]      req_address,
  input  logic [2*DATA_WIDTH-1:0]      req_write_data,
  input  logic [2*(DATA_WIDTH/8)-1:0]  req_byte_en,
  output logic [1:0]                   req_ready,
  output logic [1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         init_done,
  output logic                         mem_readEnable,
  output logic [ADDR_WIDTH-1:0]        mem_readAddress,
  input  logic [DATA_WIDTH-1:0]        mem_readData,
  output logic                         mem_writeEnable,
  output logic [DATA_WIDTH/8-1:0]      mem_writeByteEnable,
  output logic [ADDR_WIDTH-1:0]        mem_writeAddress,
  output logic [DATA_WIDTH-1:0]        mem_writeData
);

  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  arb_state_t             state;
  logic [ADDR_WIDTH-1:0]  clr_cnt;
  logic [1:0]             rsp_pend;
  logic [DATA_WIDTH-1:0]  rsp_hold;
  logic [1:0]             grant;
  logic                   rr_ptr;
  logic                   serving;
  logic                   gidx;

  // Outputs are forced quiet while reset is held so nothing reaches the
  // memory before the state register has been initialised.
  assign serving = reset && (state == ST_IDLE);

  rr_arbiter2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .enable (serving),
    .req    (req_valid),
    .grant  (grant),
    .ptr    (rr_ptr)
  );

  assign req_ready = grant;
  assign gidx      = grant[REQ1];
  assign rsp_valid = rsp_pend & {2{reset}};
  // Live memory data in the response cycle, otherwise the last response.
  assign rsp_data  = (|rsp_pend) ? mem_readData : rsp_hold;

  always_comb begin
    mem_readEnable      = 1'b0;
    mem_readAddress     = '0;
    mem_writeEnable     = 1'b0;
    mem_writeByteEnable = '0;
    mem_writeAddress    = '0;
    mem_writeData       = '0;
    if (reset) begin
      if (state == ST_CLEAR) begin
        mem_writeEnable     = 1'b1;
        mem_writeByteEnable = '1;
        mem_writeAddress    = clr_cnt;
      end else if (|grant) begin
        // A single grant means read and write are never enabled together.
        if (req_write[gidx]) begin
          mem_writeEnable     = 1'b1;
          mem_writeAddress    = gidx ? req_address[REQ1*ADDR_WIDTH +: ADDR_WIDTH]
                                     : req_address[REQ0*ADDR_WIDTH +: ADDR_WIDTH];
          mem_writeData       = gidx ? req_write_data[REQ1*DATA_WIDTH +: DATA_WIDTH]
                                     : req_write_data[REQ0*DATA_WIDTH +: DATA_WIDTH];
          mem_writeByteEnable = gidx ? req_byte_en[REQ1*BYTES +: BYTES]
                                     : req_byte_en[REQ0*BYTES +: BYTES];
        end else begin
          mem_readEnable      = 1'b1;
          mem_readAddress     = gidx ? req_address[REQ1*ADDR_WIDTH +: ADDR_WIDTH]
                                     : req_address[REQ0*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
      clr_cnt   <= '0;
      rsp_pend  <= 2'b00;
      rsp_hold  <= '0;
      init_done <= !INIT_CLEAR;
    end else begin
      rsp_pend  <= grant & ~req_write;
      if (|rsp_pend) begin
        rsp_hold <= mem_readData;
      end
      // Registered one cycle behind the state, so it rises the cycle after
      // the final sweep write has left CLEAR.
      init_done <= (state == ST_IDLE);
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsram_dual_arbiter.sv
module tb_bsram_dual_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = DW / 8;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [2*AW-1:0]   req_address;
  logic [2*DW-1:0]   req_write_data;
  logic [2*BW-1:0]   req_byte_en;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              init_done;
  logic              mem_readEnable;
  logic [AW-1:0]     mem_readAddress;
  logic [DW-1:0]     mem_readData;
  logic              mem_writeEnable;
  logic [BW-1:0]     mem_writeByteEnable;
  logic [AW-1:0]     mem_writeAddress;
  logic [DW-1:0]     mem_writeData;

  bsram_dual_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_CLEAR(1'b1)) u_dut (
    .clock               (clock),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_write           (req_write),
    .req_address         (req_address),
    .req_write_data      (req_write_data),
    .req_byte_en         (req_byte_en),
    .req_ready           (req_ready),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .init_done           (init_done),
    .mem_readEnable      (mem_readEnable),
    .mem_readAddress     (mem_readAddress),
    .mem_readData        (mem_readData),
    .mem_writeEnable     (mem_writeEnable),
    .mem_writeByteEnable (mem_writeByteEnable),
    .mem_writeAddress    (mem_writeAddress),
    .mem_writeData       (mem_writeData)
  );

  // Second instance without the zero-fill sweep.
  logic [1:0]      nc_valid;
  logic [1:0]      nc_ready;
  logic [1:0]      nc_rsp_valid;
  logic [DW-1:0]   nc_rsp_data;
  logic            nc_init_done;
  logic            nc_re, nc_we;
  logic [AW-1:0]   nc_ra, nc_wa;
  logic [BW-1:0]   nc_wbe;
  logic [DW-1:0]   nc_wd;
  logic [DW-1:0]   nc_rd = '0;

  bsram_dual_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_CLEAR(1'b0)) u_dut_nc (
    .clock               (clock),
    .reset               (reset),
    .req_valid           (nc_valid),
    .req_write           (2'b00),
    .req_address         ('0),
    .req_write_data      ('0),
    .req_byte_en         ('0),
    .req_ready           (nc_ready),
    .rsp_valid           (nc_rsp_valid),
    .rsp_data            (nc_rsp_data),
    .init_done           (nc_init_done),
    .mem_readEnable      (nc_re),
    .mem_readAddress     (nc_ra),
    .mem_readData        (nc_rd),
    .mem_writeEnable     (nc_we),
    .mem_writeByteEnable (nc_wbe),
    .mem_writeAddress    (nc_wa),
    .mem_writeData       (nc_wd)
  );

  // ---------------- memory model ----------------
  logic          preload;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_rd = '0;
  assign mem_readData = mem_rd;

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '1;
    end else begin
      if (mem_writeEnable) begin
        for (int b = 0; b < BW; b++) begin
          if (mem_writeByteEnable[b]) mem[mem_writeAddress][8*b +: 8] <= mem_writeData[8*b +: 8];
        end
      end
      if (mem_readEnable) mem_rd <= mem[mem_readAddress];
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [3:0]  a0;
    logic [31:0] d0;
    logic [3:0]  be0;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic [3:0]  be1;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rv;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w,
                              input logic [3:0] a0, input logic [31:0] d0, input logic [3:0] be0,
                              input logic [3:0] a1, input logic [31:0] d1, input logic [3:0] be1,
                              input logic [1:0] er, input logic [1:0] erv, input logic [31:0] ed);
    vec_t r;
    r.valid = v;  r.write = w;
    r.a0 = a0;    r.d0 = d0;  r.be0 = be0;
    r.a1 = a1;    r.d1 = d1;  r.be1 = be1;
    r.exp_ready = er; r.exp_rv = erv; r.exp_data = ed;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    req_valid      = v.valid;
    req_write      = v.write;
    req_address    = {v.a1, v.a0};
    req_write_data = {v.d1, v.d0};
    req_byte_en    = {v.be1, v.be0};
  endtask

  task automatic drive_idle();
    req_valid      = 2'b00;
    req_write      = 2'b00;
    req_address    = '0;
    req_write_data = '0;
    req_byte_en    = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Called right after reset is released; checks every sweep cycle and
  // returns the number of cycles until init_done is seen high.
  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 100) begin
      @(negedge clock);
      if (cycles < DEPTH) begin
        check($sformatf("sweep_c%0d", cycles),
              64'({req_ready, mem_writeEnable, mem_readEnable, mem_writeAddress,
                   mem_writeByteEnable, mem_writeData}),
              64'({2'b00, 1'b1, 1'b0, 4'(cycles), 4'hF, 32'h0}));
      end
      next_cycle();
      cycles++;
      if (cycles == 8) req_valid = 2'b00;
    end
  endtask

  logic [3:0] r0_addr [3];
  int         c_init;
  int         r0_i;
  int         waited;
  logic       granted;
  logic       rdy0;
  logic       found;

  initial begin
    vecs[0]  = mk(2'b01, 2'b01, 4'd2, 32'hAAAA8888, 4'hF, 4'd0, '0, '0, 2'b01, 2'b00, '0);
    vecs[1]  = mk(2'b10, 2'b10, 4'd0, '0, '0, 4'd4, 32'h11110000, 4'hF, 2'b10, 2'b00, '0);
    vecs[2]  = mk(2'b01, 2'b00, 4'd2, '0, '0, 4'd0, '0, '0, 2'b01, 2'b00, '0);
    vecs[3]  = mk(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, 2'b01, 32'hAAAA8888);
    vecs[4]  = mk(2'b10, 2'b10, 4'd0, '0, '0, 4'd2, 32'h00000064, 4'b0011, 2'b10, 2'b00, '0);
    vecs[5]  = mk(2'b10, 2'b00, 4'd0, '0, '0, 4'd2, '0, '0, 2'b10, 2'b00, '0);
    vecs[6]  = mk(2'b01, 2'b01, 4'd2, 32'hDEADBEEF, 4'h0, 4'd0, '0, '0, 2'b01, 2'b10, 32'hAAAA0064);
    vecs[7]  = mk(2'b01, 2'b00, 4'd2, '0, '0, 4'd0, '0, '0, 2'b01, 2'b00, '0);
    vecs[8]  = mk(2'b10, 2'b10, 4'd0, '0, '0, 4'd2, 32'hAAAA8888, 4'hF, 2'b10, 2'b01, 32'hAAAA0064);
    vecs[9]  = mk(2'b11, 2'b00, 4'd4, '0, '0, 4'd2, '0, '0, 2'b01, 2'b00, '0);
    vecs[10] = mk(2'b11, 2'b00, 4'd4, '0, '0, 4'd2, '0, '0, 2'b10, 2'b01, 32'h11110000);
    vecs[11] = mk(2'b11, 2'b00, 4'd4, '0, '0, 4'd2, '0, '0, 2'b01, 2'b10, 32'hAAAA8888);
    vecs[12] = mk(2'b11, 2'b00, 4'd4, '0, '0, 4'd2, '0, '0, 2'b10, 2'b01, 32'h11110000);
    vecs[13] = mk(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, 2'b10, 32'hAAAA8888);
    vecs[14] = mk(2'b11, 2'b01, 4'd5, 32'hCAFEF00D, 4'hF, 4'd4, '0, '0, 2'b01, 2'b00, '0);
    vecs[15] = mk(2'b10, 2'b00, 4'd0, '0, '0, 4'd4, '0, '0, 2'b10, 2'b00, '0);
    vecs[16] = mk(2'b01, 2'b00, 4'd5, '0, '0, 4'd0, '0, '0, 2'b01, 2'b10, 32'h11110000);
    vecs[17] = mk(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, 2'b01, 32'hCAFEF00D);
    r0_addr[0] = 4'd4; r0_addr[1] = 4'd5; r0_addr[2] = 4'd2;

    // ---- reset and reset values ----
    preload  = 1'b1;
    nc_valid = 2'b00;
    drive_idle();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 64'(req_ready), 64'(2'b00));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check("rst_init_done", 64'(init_done), 64'(1'b0));
    check("rst_mem_en", 64'({mem_readEnable, mem_writeEnable}), 64'(2'b00));
    check("rst_mem_addr_data", 64'({mem_readAddress, mem_writeAddress, mem_writeData}), 64'(0));
    check("nc_rst_init_done", 64'(nc_init_done), 64'(1'b1));
    preload = 1'b0;

    // ---- zero-fill sweep with both requesters pushing ----
    req_valid = 2'b11;
    @(posedge clock);
    #1 reset = 1'b1;
    nc_valid = 2'b01;
    @(negedge clock);
    check("nc_ready_no_sweep", 64'(nc_ready), 64'(2'b01));
    @(posedge clock);
    #1 nc_valid = 2'b00;
    // One cycle of the sweep already passed above; restart it for a clean count.
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    wait_init(c_init);
    check("init_latency", 64'(c_init), 64'(17));

    // ---- every address reads back as zero ----
    for (int i = 0; i <= DEPTH; i++) begin
      drive_idle();
      if (i < DEPTH) begin
        req_valid   = 2'b01;
        req_address = {4'd0, 4'(i)};
      end
      @(negedge clock);
      if (i < DEPTH) check($sformatf("clr_rd_ready_%0d", i), 64'(req_ready), 64'(2'b01));
      if (i > 0) begin
        check($sformatf("clr_rd_valid_%0d", i - 1), 64'(rsp_valid), 64'(2'b01));
        check($sformatf("clr_rd_data_%0d", i - 1), 64'(rsp_data), 64'(0));
      end
      next_cycle();
    end

    // ---- table: single ops, byte writes, contention ----
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(negedge clock);
      check($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].exp_rv));
      if (vecs[i].exp_rv != 2'b00)
        check($sformatf("v%0d_rsp_data", i), 64'(rsp_data), 64'(vecs[i].exp_data));
      check($sformatf("v%0d_mem_excl", i), 64'(mem_readEnable & mem_writeEnable), 64'(1'b0));
      next_cycle();
    end

    // ---- held request while requester 0 streams reads ----
    drive_idle();
    req_valid   = 2'b01;
    req_address = {4'd0, r0_addr[0]};
    @(negedge clock);
    check("held_a_ready", 64'(req_ready), 64'(2'b01));
    next_cycle();
    r0_i    = 1;
    granted = 1'b0;
    waited  = 0;
    while (!granted && waited < 4) begin
      req_valid   = 2'b11;
      req_address = {4'd2, r0_addr[r0_i]};
      @(negedge clock);
      rdy0 = req_ready[0];
      if (req_ready[1]) begin
        granted = 1'b1;
        check("held_addr", 64'({mem_readEnable, mem_readAddress}), 64'({1'b1, 4'd2}));
      end
      next_cycle();
      if (rdy0 && r0_i < 2) r0_i++;
      if (!granted) waited++;
    end
    check("held_grant_latency", 64'({granted, waited <= 1}), 64'(2'b11));
    req_valid   = 2'b01;
    req_address = {4'd0, r0_addr[1]};
    @(negedge clock);
    check("held_r1_rsp", 64'({rsp_valid, rsp_data}), 64'({2'b10, 32'hAAAA8888}));
    check("held_r0_b_ready", 64'(req_ready), 64'(2'b01));
    next_cycle();
    req_address = {4'd0, r0_addr[2]};
    @(negedge clock);
    check("held_r0_b_rsp", 64'({rsp_valid, rsp_data}), 64'({2'b01, 32'hCAFEF00D}));
    next_cycle();
    drive_idle();
    @(negedge clock);
    check("held_r0_c_rsp", 64'({rsp_valid, rsp_data}), 64'({2'b01, 32'hAAAA8888}));
    next_cycle();

    // ---- reset with a read response pending ----
    req_valid   = 2'b01;
    req_address = {4'd0, 4'd2};
    @(negedge clock);
    check("pend_ready", 64'(req_ready), 64'(2'b01));
    @(posedge clock);
    #1 reset = 1'b0;
    drive_idle();
    @(negedge clock);
    check("pend_rsp_suppressed_a", 64'(rsp_valid), 64'(2'b00));
    next_cycle();
    @(negedge clock);
    check("pend_rsp_suppressed_b", 64'(rsp_valid), 64'(2'b00));
    next_cycle();
    reset = 1'b1;

    // ---- reset in the middle of the sweep ----
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clock);
      if (mem_writeEnable && mem_writeAddress == 4'd7) found = 1'b1;
      else next_cycle();
    end
    check("midclr_reached_7", 64'(found), 64'(1'b1));
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    wait_init(c_init);
    check("midclr_init_latency", 64'(c_init), 64'(17));

    // Address 2 held AAAA8888 before the sweep.
    req_valid   = 2'b01;
    req_address = {4'd0, 4'd2};
    @(negedge clock);
    check("post_clr_ready", 64'(req_ready), 64'(2'b01));
    next_cycle();
    drive_idle();
    @(negedge clock);
    check("post_clr_rsp", 64'({rsp_valid, rsp_data}), 64'({2'b01, 32'h0}));
    next_cycle();

    // ---- report ----
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bsram_dual_arbiter.md
Name: bsram_dual_arbiter

Overview:
- Shares one byte-enable synchronous BSRAM (1-cycle read latency, byte-masked write) between two requesters, e.g. the instruction fetch and data access paths of a small core.
- After reset, optionally sweeps the whole array to zero before serving any requests.
- Arbitrates with fair round-robin and returns read data to the winning requester one cycle after grant.
- Sits between the requesters and the memory instance, and drives all of the memory's read and write control.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 8, word address width; depth = 2**ADDR_WIDTH.
- INIT_CLEAR, 1, when 1 the block zero-fills the memory after reset; when 0 it goes straight to IDLE.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_write  in  2  per-requester op select: 1 = write, 0 = read.
- req_address  in  2*ADDR_WIDTH  per-requester word address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_write_data  in  2*DATA_WIDTH  per-requester write data, same slicing.
- req_byte_en  in  2*DATA_WIDTH/8  per-requester byte enables, same slicing.
- req_ready  out  2  per-requester grant; a request is accepted when valid & ready.
- rsp_valid  out  2  per-requester read-data valid; single-cycle pulse.
- rsp_data  out  DATA_WIDTH  read data, shared by both requesters; qualified by rsp_valid.
- init_done  out  1  high once the zero-fill is finished, or immediately when INIT_CLEAR=0.
- mem_readEnable  out  1  memory read enable.
- mem_readAddress  out  ADDR_WIDTH  memory read address.
- mem_readData  in  DATA_WIDTH  memory read data; valid the cycle after mem_readEnable.
- mem_writeEnable  out  1  memory write enable.
- mem_writeByteEnable  out  DATA_WIDTH/8  memory byte-enable mask.
- mem_writeAddress  out  ADDR_WIDTH  memory write address.
- mem_writeData  out  DATA_WIDTH  memory write data.

Behaviour:
- State machine: CLEAR, IDLE.
  - Reset low at a clock edge: state = CLEAR if INIT_CLEAR else IDLE; clr_cnt = 0; rr_ptr = 0; rsp_pend = 0.
- Reset values of outputs:
  - req_ready = 0, rsp_valid = 0, init_done = 0 (1 if INIT_CLEAR=0).
  - All mem_* enables = 0; mem addresses and data = 0.
- CLEAR state:
  - Each cycle: mem_writeEnable = 1, mem_writeByteEnable = all ones, mem_writeAddress = clr_cnt, mem_writeData = 0; clr_cnt increments.
  - req_ready = 0 throughout.
  - After the write at address 2**ADDR_WIDTH-1, go to IDLE; init_done rises the next cycle.
  - Total duration is 2**ADDR_WIDTH cycles.
- IDLE state:
  - req_ready is combinational and one-hot or zero; at most one grant per cycle.
  - Only one valid requester: it is granted.
  - Both valid: requester rr_ptr is granted, then rr_ptr = ~granted index.
  - Single grants also set rr_ptr = ~granted index.
- Granted read:
  - Same cycle: mem_readEnable = 1, mem_readAddress = that requester's address.
  - Next cycle: rsp_valid[i] = 1, rsp_data = mem_readData.
  - Back-to-back reads give one response per cycle, in grant order.
- Granted write:
  - Same cycle: mem_writeEnable = 1, with address, data and byte_en from the requester.
  - A write with byte_en = 0 is still accepted and leaves memory unchanged.
  - Writes produce no response.
- Write then read of the same address on consecutive cycles: the read returns the updated data. This relies on the memory's write-first sequencing; no bypass logic in this block.
- Requester obligations: address, data and op must be held stable while valid & !ready. The arbiter never drops an asserted request.
- When a requester is not granted, its rsp_valid stays 0.
- rsp_data holds its last value when no response is pending; the bench must not check it then.
- Reset asserted mid-CLEAR: the sweep restarts from 0.
- Reset asserted with a read response pending: the response is discarded and rsp_valid stays 0.
- The mem_read and mem_write paths are never both enabled in the same cycle.

Decomposition:
- Package bsram_arb_pkg holds:
  - the state encoding (CLEAR = 1'b0, IDLE = 1'b1);
  - the requester index constants REQ0 = 0, REQ1 = 1;
  - the function bytes_of(DATA_WIDTH).
- One sub-module, rr_arbiter2: 2-input round-robin grant with a pointer register. It is reusable by the cache and bus code.
- The memory itself is instantiated outside this block, at the level above.

Test Plan:
- Clear: INIT_CLEAR=1, ADDR_WIDTH=4, memory preloaded with 32'hFFFFFFFF -> init_done rises 17 cycles after reset deasserts; reads of addresses 0..15 return 0; req_ready is 0 during the sweep.
- Single read: memory[2] = 32'hAAAA8888, requester 0 reads address 2 -> granted in the same cycle; the next cycle rsp_valid = 2'b01 and rsp_data = 32'hAAAA8888.
- Byte write: requester 1 writes 32'h00000064 with byte_en 4'b0011 to address 2, then reads address 2 -> rsp_data = 32'hAAAA0064, rsp_valid = 2'b10.
- Contention: both requesters hold reads to addresses 4 and 2 for 4 cycles -> grants alternate 01, 10, 01, 10; responses 32'h11110000 and 32'hAAAA8888 alternate on the matching rsp_valid bit.
- Held request: requester 1 is valid while requester 0 streams 3 reads -> requester 1 is granted within 1 cycle of its first valid, and its address is sampled unchanged.
- Reset mid-op: assert reset during CLEAR at clr_cnt = 7, and separately in the cycle after a read grant -> the sweep restarts at 0 (full 17 cycles again); the pending rsp_valid is suppressed.
